serial_pattern_scanner: RTL and testbench
=========================================

Name: serial_pattern_scanner

Overview:
Sequencing controller that accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, through an internal programmable serial pattern matcher (Mealy-style, e.g. 1101). It supports overlapping and non-overlapping detection, emits a per-match pulse and counts matches per word. It signals completion with a done pulse. It sits between a word-oriented producer and downstream match-event logic.

Parameters:
WORD_W, 16, width of each input word and number of serial bits scanned per word
PAT_W, 4, pattern length in bits (1..WORD_W)
CNT_W, 5, width of per-word match counter

Ports:
clk  input  1  clock
rst  input  1  reset
cfg_we  input  1  config write strobe; honoured only in IDLE
cfg_pattern  input  PAT_W  pattern to detect; MSB is matched first
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  input word valid
in_ready  output  1  scanner can accept a word
in_data  input  WORD_W  word to scan, MSB first
busy  output  1  word being scanned
hit  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in current/last word
done  output  1  one-cycle pulse: word fully scanned, match_count final

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset forces: state IDLE; pattern register 0; overlap register 0; history, fill and bit index 0; busy=0, hit=0, done=0, match_count=0. in_ready=1 in the cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - cfg_we=1 loads cfg_pattern and cfg_overlap at the clock edge.
  - in_valid&&in_ready latches in_data, sets index=WORD_W-1, clears history/fill/match_count, and moves to SHIFT.
  - If cfg_we and acceptance occur in the same cycle, the config write is applied first, so the new word uses the new config.
- SHIFT:
  - in_ready=0, busy=1. cfg_we is ignored.
  - SHIFT cycle k (k=0..WORD_W-1) consumes bit in_data[WORD_W-1-k].
  - Candidate = {history[PAT_W-2:0], bit}. If PAT_W=1, candidate = bit.
  - A match occurs when fill+1 >= PAT_W and candidate == pattern.
  - On a match, hit=1 during cycle k+1 (registered) and match_count increments at the same edge. match_count saturates at all-ones.
  - Overlap=1: history shifts in the bit and fill advances (saturating at PAT_W).
  - Overlap=0 and match: history and fill clear to 0, so the next match needs PAT_W fresh bits.
  - No match: history shifts in the bit and fill advances.
  - After the bit at index 0 is consumed, move to DONE.
- DONE (one cycle):
  - done=1, busy=0, in_ready=0. match_count includes any hit from the final bit.
  - hit may be 1 in this same cycle if the last bit matched.
  - Next state is IDLE.
- Latency: word accepted at edge E0, SHIFT occupies WORD_W cycles, done is high in cycle WORD_W+1 after E0. Minimum word-to-word spacing is WORD_W+2 cycles.
- Matches never span words; history is cleared on each accept.
- match_count holds its value after done until the next accept.
- in_data is not required to be stable after acceptance.
- Reset during SHIFT aborts the word: no done pulse and no hit follow, and match_count reads 0.

Test Plan:
- Overlap: cfg pattern=4'b1101, overlap=1; send 16'b1101101101100000 -> hit in SHIFT cycles 4, 7, 10 (after consuming bits 3, 6, 9); done at cycle 17 after accept; match_count=3.
- Non-overlap: same word, overlap=0 -> hit after bits 3 and 9 only; match_count=2 at done.
- Handshake/back-to-back: hold in_valid=1 with two words -> second accepted exactly 18 cycles after the first; in_ready=0 throughout SHIFT and DONE; no word is lost or duplicated.
- Config lock: cfg_we with pattern 4'b0000 during SHIFT of the first word -> ignored, first word still matches 1101. cfg_we in IDLE takes effect on the next word: all-zeros word, overlap=1 -> match_count=13.
- Last-bit match: word 16'b0000000000001101, pattern 1101 -> hit and done in the same cycle; match_count=1.
- Reset mid-operation: assert rst at SHIFT cycle 5 -> next cycle busy=0, in_ready=1, match_count=0, no done or hit pulse. The next word is scanned correctly.

Source files
------------

// File: rtl/serial_pattern_scanner_if.sv
// Handshake and status bundle for serial_pattern_scanner.
//   master : word producer / configuration side (drives cfg_*, in_valid, in_data)
//   slave  : the scanner (drives in_ready, busy, hit, match_count, done)
// Signals:
//   cfg_we, cfg_pattern[PAT_W], cfg_overlap  - configuration write (IDLE only)
//   in_valid, in_ready, in_data[WORD_W]      - word handshake, data scanned MSB first
//   busy, hit, match_count[CNT_W], done      - scan status and match events
interface serial_pattern_scanner_if #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              busy;
    logic              hit;
    logic [CNT_W-1:0]  match_count;
    logic              done;

    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, in_valid, in_data,
        input  in_ready, busy, hit, match_count, done
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, in_valid, in_data,
        output in_ready, busy, hit, match_count, done
    );
endinterface

// File: rtl/serial_pattern_scanner.sv
// Serial pattern scanner: accepts a parallel word over valid/ready, then
// shifts it MSB first, one bit per clock, through a programmable PAT_W-bit
// pattern matcher with overlapping or non-overlapping detection.
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - serial_pattern_scanner_if.slave (config, word handshake, status)
//         hit is a registered one-cycle pulse per match, match_count counts
//         matches in the current/last word, done pulses once per scanned word.
module serial_pattern_scanner #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_pattern_scanner_if.slave bus
);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int HW = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam int FW = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [HW-1:0]     hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hit_q, hit_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;

    logic              rdy_c, busy_c, done_c;
    logic              bit_w;
    logic [PAT_W-1:0]  cand_w;
    logic [HW-1:0]     hist_shift_w;
    logic              match_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FW-1:0] fill_adv(input logic [FW-1:0] v);
        return (v >= FW'(PAT_W)) ? v : v + FW'(1);
    endfunction

    assign bit_w = data_q[idx_q];

    // Candidate window: the last PAT_W-1 bits seen plus the current bit.
    generate
        if (PAT_W > 1) begin : g_multi
            assign cand_w       = {hist_q[HW-1:0], bit_w};
            assign hist_shift_w = cand_w[HW-1:0];
        end else begin : g_single
            assign cand_w       = bit_w;
            assign hist_shift_w = '0;
        end
    endgenerate

    // Only a window made entirely of bits from this word (since the last
    // clear) may match.
    assign match_w = (fill_q >= FW'(PAT_W - 1)) && (cand_w == pat_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        rdy_c   = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdy_c = 1'b1;
                // The config register loads at the same edge as the word, so
                // a simultaneous write applies to that word.
                if (bus.cfg_we) begin
                    pat_d = bus.cfg_pattern;
                    ovl_d = bus.cfg_overlap;
                end
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    idx_d   = IW'(WORD_W - 1);
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy_c = 1'b1;
                if (match_w) begin
                    hit_d = 1'b1;
                    cnt_d = sat_inc(cnt_q);
                    if (ovl_q) begin
                        hist_d = hist_shift_w;
                        fill_d = fill_adv(fill_q);
                    end else begin
                        // Non-overlapping: the next match needs PAT_W fresh bits.
                        hist_d = '0;
                        fill_d = '0;
                    end
                end else begin
                    hist_d = hist_shift_w;
                    fill_d = fill_adv(fill_q);
                end
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    // Word buffer carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.in_ready    = rdy_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.hit         = hit_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_serial_pattern_scanner.sv
module tb_serial_pattern_scanner;
    localparam int W = 16;
    localparam int P = 4;
    localparam int C = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_pattern_scanner_if #(.WORD_W(W), .PAT_W(P), .CNT_W(C)) ifc ();

    serial_pattern_scanner #(.WORD_W(W), .PAT_W(P), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which serial bit positions (0 = MSB, first scanned) complete a match,
    // found by comparing whole PAT-wide windows of the word to the pattern.
    function automatic logic [W-1:0] model_hits(input logic [W-1:0] w,
                                                input logic [P-1:0] p,
                                                input logic ov);
        logic [W-1:0] hv;
        int last;
        bit ok;
        hv = '0;
        last = -1;
        for (int k = P - 1; k < W; k++) begin
            if (!ov && (k - P + 1) <= last) continue;
            ok = 1'b1;
            for (int i = 0; i < P; i++)
                if (w[W - 1 - (k - P + 1 + i)] != p[P - 1 - i]) ok = 1'b0;
            if (ok) begin
                hv[k] = 1'b1;
                last = k;
            end
        end
        return hv;
    endfunction

    // Model timeline: m_t = 0 idle, 1..W shift cycles, W+1 done cycle.
    int              cyc = 0;
    int              m_t = 0;
    logic [W-1:0]    m_hv = '0;
    logic [P-1:0]    m_pat = '0;
    logic            m_ovl = 1'b0;
    logic [C-1:0]    m_hold = '0;
    int              acc_n = 0;
    int              acc_last = 0;
    int              acc_prev = 0;

    // Hits for bit k are visible from cycle k+2 of the timeline.
    function automatic logic [C-1:0] exp_cnt(input int t);
        int n;
        n = 0;
        for (int k = 0; k < W; k++)
            if (m_hv[k] && (k + 2) <= t) n++;
        if (n > (2 ** C) - 1) n = (2 ** C) - 1;
        return C'(n);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_t = 0; m_pat = '0; m_ovl = 1'b0; m_hold = '0; m_hv = '0;
        end else if (m_t == 0) begin
            if (ifc.cfg_we) begin
                m_pat = ifc.cfg_pattern;
                m_ovl = ifc.cfg_overlap;
            end
            if (ifc.in_valid) begin
                m_hv = model_hits(ifc.in_data, m_pat, m_ovl);
                m_t = 1;
                acc_prev = acc_last;
                acc_last = cyc;
                acc_n++;
            end
        end else if (m_t == W + 1) begin
            m_hold = exp_cnt(W + 1);
            m_t = 0;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", ifc.in_ready, (m_t == 0));
            check("busy", ifc.busy, (m_t >= 1 && m_t <= W));
            check("done", ifc.done, (m_t == W + 1));
            check("hit", ifc.hit, (m_t >= 2) ? m_hv[m_t - 2] : 1'b0);
            check("match_count", ifc.match_count, (m_t == 0) ? m_hold : exp_cnt(m_t));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [P-1:0] p, input logic ov);
        ifc.cfg_we = 1'b1;
        ifc.cfg_pattern = p;
        ifc.cfg_overlap = ov;
        tick();
        ifc.cfg_we = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w, input bit keep_valid);
        int pre;
        bit got;
        pre = acc_n;
        got = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data = w;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (acc_n != pre) got = 1'b1;
        end
        if (!got) check("accept_timeout", 0, 1);
        if (!keep_valid) ifc.in_valid = 1'b0;
        ifc.in_data = W'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (m_t == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        ifc.cfg_we = 1'b0;
        ifc.cfg_pattern = '0;
        ifc.cfg_overlap = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        tick();
        check("rst_in_ready", ifc.in_ready, 1);
        check("rst_busy", ifc.busy, 0);
        check("rst_count", ifc.match_count, 0);

        check("pin_overlap", model_hits(16'hDB60, 4'hD, 1'b1), 16'h0248);
        check("pin_nonoverlap", model_hits(16'hDB60, 4'hD, 1'b0), 16'h0208);
        check("pin_zeros", model_hits(16'h0000, 4'h0, 1'b1), 16'hFFF8);
        check("pin_zeros_nov", model_hits(16'h0000, 4'h0, 1'b0), 16'h8888);
        check("pin_lastbit", model_hits(16'h000D, 4'hD, 1'b1), 16'h8000);

        // Overlapping detection.
        cfg(4'hD, 1'b1);
        send(16'hDB60, 1'b0);
        repeat (W) tick();
        check("ovl_done", ifc.done, 1);
        check("ovl_count", ifc.match_count, 3);
        wait_idle();

        // Non-overlapping detection.
        cfg(4'hD, 1'b0);
        send(16'hDB60, 1'b0);
        repeat (W) tick();
        check("novl_done", ifc.done, 1);
        check("novl_count", ifc.match_count, 2);
        wait_idle();

        // Back-to-back with in_valid held high.
        cfg(4'hD, 1'b1);
        send(16'hDB60, 1'b1);
        send(16'h000D, 1'b0);
        check("b2b_spacing", acc_last - acc_prev, W + 2);
        wait_idle();
        check("b2b_count", ifc.match_count, 1);

        // Config writes during SHIFT are ignored; in IDLE they take effect.
        send(16'hDB60, 1'b0);
        tick();
        ifc.cfg_we = 1'b1;
        ifc.cfg_pattern = 4'h0;
        ifc.cfg_overlap = 1'b1;
        tick();
        ifc.cfg_we = 1'b0;
        wait_idle();
        check("lock_count", ifc.match_count, 3);
        cfg(4'h0, 1'b1);
        send(16'h0000, 1'b0);
        wait_idle();
        check("zeros_count", ifc.match_count, 13);

        // Match on the final bit: hit and done together.
        cfg(4'hD, 1'b1);
        send(16'h000D, 1'b0);
        repeat (W) tick();
        check("last_hit", ifc.hit, 1);
        check("last_done", ifc.done, 1);
        check("last_count", ifc.match_count, 1);
        wait_idle();

        // Reset in SHIFT cycle 5 aborts the word.
        send(16'hDB60, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", ifc.busy, 0);
        check("abort_ready", ifc.in_ready, 1);
        check("abort_count", ifc.match_count, 0);
        repeat (3) tick();
        cfg(4'hD, 1'b1);
        send(16'hDB60, 1'b0);
        wait_idle();
        check("after_abort_count", ifc.match_count, 3);

        // Randomized traffic, config writes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            ifc.in_valid = ($urandom_range(0, 2) == 0);
            ifc.cfg_we = ($urandom_range(0, 3) == 0);
            ifc.cfg_pattern = P'($urandom);
            ifc.cfg_overlap = 1'($urandom);
            ifc.in_data = ($urandom_range(0, 1) == 0) ? {(W / P){m_pat}} : W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        ifc.in_valid = 1'b0;
        ifc.cfg_we = 1'b0;
        rst = 1'b0;
        wait_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
